if_prefetch_buffer: RTL and testbench
=====================================

Name: if_prefetch_buffer

Overview:
Fetch front end sitting upstream of the pipelined core's IF/ID register. It issues sequential instruction reads to a variable-latency instruction memory and buffers returned words with their PCs in a small FIFO. It presents them to the core through a valid/ready interface. Branch redirects from EX flush the buffer, restart fetch at the target, and discard responses still in flight.

Parameters:
XLEN, 32, datapath and PC width (riscv_pkg value)
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 4, FIFO entries and max outstanding-plus-buffered words; power of 2, >= 2

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
imem_req_valid  out  1  read request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word-aligned read address
imem_rsp_valid  in  1  read data returned; one-cycle pulse, in order, no backpressure
imem_rsp_data  in  32  returned instruction word
redirect_valid  in  1  branch taken (EX branch_taken)
redirect_pc  in  XLEN  branch target
fetch_ready  in  1  core accepts head entry (low = pc_stall)
fetch_valid  out  1  head entry valid
fetch_pc  out  XLEN  PC of head entry
fetch_instr  out  32  instruction of head entry

Behaviour:
- Interface: one clock, clk. Synchronous active-high reset, reset. All state updates on the rising edge of clk.
- State:
  - FIFO of DEPTH entries {pc, instr}: rd/wr pointers plus count (0..DEPTH).
  - req_pc: next address to request.
  - rsp_pc: PC of the next non-discarded response.
  - outstanding: accepted, unanswered requests (0..DEPTH).
  - discard: responses still to drop (<= outstanding).
- Reset:
  - count, outstanding and discard = 0; req_pc = rsp_pc = RESET_PC.
  - imem_req_valid = 0 and fetch_valid = 0 while reset is high.
  - Reset mid-operation drops everything; late responses arriving after reset are ignored because outstanding = 0.
- Issue:
  - imem_req_valid = !reset && !redirect_valid && (count + outstanding < DEPTH).
  - imem_req_addr = req_pc.
  - On accept (valid && ready): req_pc += 4 (wraps mod 2^XLEN) and outstanding increments.
- Response:
  - On imem_rsp_valid, outstanding decrements.
  - If discard != 0: discard decrements and the word is dropped.
  - Otherwise: push {rsp_pc, data} and rsp_pc += 4.
  - Credit rule guarantees the FIFO is never full on a push.
  - A response with outstanding = 0 is a protocol error; ignore it (assertion in the bench).
- Output:
  - fetch_valid = (count != 0) && !redirect_valid; fetch_pc and fetch_instr show the head entry.
  - Pop on fetch_valid && fetch_ready. Push and pop in the same cycle leave count unchanged.
  - Outputs hold stable while fetch_ready = 0.
- Redirect (highest priority, single cycle):
  - FIFO is emptied; any pop that cycle is ignored.
  - req_pc and rsp_pc take redirect_pc with bits[1:0] forced to 0.
  - No request is issued that cycle.
  - discard_next = outstanding - rsp_valid; outstanding_next = outstanding - rsp_valid. A response in the redirect cycle is dropped.
  - Back-to-back redirects: the last one wins; the discard count is recomputed each cycle.
- Latency:
  - Memory response comes >= 1 cycle after accept.
  - With zero-wait memory: request accepted in cycle N, response in N+1, fetch_valid in N+2.
  - Sustained throughput is 1 instr/cycle when DEPTH >= memory latency + 1.
- Widths:
  - count and outstanding are $clog2(DEPTH+1) bits.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.

Test Plan:
- Reset, then 1-cycle memory with ready = 1 and fetch_ready = 1 -> addrs 0,4,8,... issued one per cycle; first fetch_valid 2 cycles after the first accept with pc = 0; pcs then consecutive.
- fetch_ready = 0 for 10 cycles -> exactly DEPTH = 4 words are buffered or outstanding, then imem_req_valid = 0. Head holds pc 0x0 stable. Releasing ready drains 0,4,8,C in order.
- 3-cycle memory latency with 2 outstanding, redirect_pc = 0x100 -> the 2 in-flight responses are dropped. The next fetch_valid shows pc 0x100 with the memory word at 0x100, never stale data.
- Redirect in the same cycle as imem_rsp_valid and fetch_ready -> response dropped, no pop observed. discard = outstanding - 1; next request addr = 0x100.
- imem_req_ready toggling 1010... and fetch_ready random, plus a redirect to 0xFFFF_FFFC -> PCs strictly sequential +4, wrapping to 0x0. No loss or duplication against the reference model.
- Assert reset while 2 requests are outstanding, then inject their responses -> ignored; fetch restarts at RESET_PC with fetch_valid = 0 until the new response arrives.

Source files
------------

// File: rtl/if_prefetch_buffer_if.sv
// rtl/if_prefetch_buffer_if.sv - fetch front end bus: imem request/response, redirect and core fetch stream
interface if_prefetch_buffer_if #(
   parameter int XLEN = 32
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [31:0]     imem_rsp_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            fetch_ready;
   logic            fetch_valid;
   logic [XLEN-1:0] fetch_pc;
   logic [31:0]     fetch_instr;

   modport master (
      output imem_req_valid, imem_req_addr, fetch_valid, fetch_pc, fetch_instr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, fetch_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, fetch_valid, fetch_pc, fetch_instr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, fetch_ready
   );
endinterface

// File: rtl/if_prefetch_buffer.sv
// rtl/if_prefetch_buffer.sv - sequential instruction prefetcher with PC-tagged FIFO and redirect flush
module if_prefetch_buffer #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   if_prefetch_buffer_if.master  bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [XLEN-1:0] r_fifo_pc    [DEPTH];
   logic [31:0]     r_fifo_instr [DEPTH];
   logic [PW-1:0]   r_rd_ptr;
   logic [PW-1:0]   r_wr_ptr;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   r_outstanding;
   logic [CW-1:0]   r_discard;
   logic [XLEN-1:0] r_req_pc;
   logic [XLEN-1:0] r_rsp_pc;

   logic            w_credit;
   logic            w_req_valid;
   logic            w_req_fire;
   logic            w_rsp_ok;
   logic            w_push;
   logic            w_fetch_valid;
   logic            w_pop;
   logic [XLEN-1:0] w_redirect_pc;

   // Buffered plus in-flight words never exceed DEPTH, so a push always finds room.
   assign w_credit      = ({1'b0, r_count} + {1'b0, r_outstanding}) < (CW + 1)'(DEPTH);
   assign w_req_valid   = !reset && !bus.redirect_valid && w_credit;
   assign w_req_fire    = w_req_valid && bus.imem_req_ready;
   assign w_rsp_ok      = bus.imem_rsp_valid && (r_outstanding != '0);
   assign w_push        = w_rsp_ok && (r_discard == '0) && !bus.redirect_valid;
   assign w_fetch_valid = !reset && !bus.redirect_valid && (r_count != '0);
   assign w_pop         = w_fetch_valid && bus.fetch_ready;
   assign w_redirect_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};

   assign bus.imem_req_valid = w_req_valid;
   assign bus.imem_req_addr  = r_req_pc;
   assign bus.fetch_valid    = w_fetch_valid;
   assign bus.fetch_pc       = r_fifo_pc[r_rd_ptr];
   assign bus.fetch_instr    = r_fifo_instr[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset && w_push) begin
         r_fifo_pc[r_wr_ptr]    <= r_rsp_pc;
         r_fifo_instr[r_wr_ptr] <= bus.imem_rsp_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
         r_outstanding <= '0;
         r_discard     <= '0;
         r_req_pc      <= RESET_PC;
         r_rsp_pc      <= RESET_PC;
      end else if (bus.redirect_valid) begin
         // Everything still in flight after this cycle belongs to the old path.
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
         r_outstanding <= r_outstanding - CW'(w_rsp_ok);
         r_discard     <= r_outstanding - CW'(w_rsp_ok);
         r_req_pc      <= w_redirect_pc;
         r_rsp_pc      <= w_redirect_pc;
      end else begin
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_rsp_pc <= r_rsp_pc + XLEN'(4);
         end
         if (w_req_fire) begin
            r_req_pc <= r_req_pc + XLEN'(4);
         end
         if (w_rsp_ok && (r_discard != '0)) begin
            r_discard <= r_discard - 1'b1;
         end
         r_count       <= r_count + CW'(w_push) - CW'(w_pop);
         r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_ok);
      end
   end
endmodule

// File: tb/tb_if_prefetch_buffer.sv
// tb/tb_if_prefetch_buffer.sv - randomized self-checking bench for if_prefetch_buffer
module tb_if_prefetch_buffer;
   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   if_prefetch_buffer_if #(.XLEN(XLEN)) bus ();

   if_prefetch_buffer #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // reference model state
   ent_t        mbuf[$];
   int          m_inflight;
   int          m_drop;
   logic [31:0] m_req_pc;
   logic [31:0] m_rsp_pc;

   // memory and stimulus control
   mreq_t       memq[$];
   int          last_due = 0;
   int          lat = 1;
   int          rdy_mode = 0;
   int          fr_mode = 1;
   int          redir_rate = 0;
   logic        f_reset = 1'b1;
   logic        f_redir = 1'b0;
   logic [31:0] f_redir_pc = '0;
   logic        keep_mem = 1'b0;
   logic        allow_stray = 1'b0;

   // observations
   logic [31:0] popped[$];
   logic [31:0] popped_instr[$];
   logic [31:0] fire_addrs[$];
   int          fires = 0;
   int          first_fire = -1;
   int          first_fv = -1;
   logic        obs_rv, obs_fv, obs_rsp;
   logic [31:0] obs_pc;

   function automatic logic [31:0] mdat(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic compare();
      logic exp_rv, exp_fv;
      exp_rv = !reset && !bus.redirect_valid && (mbuf.size() + m_inflight < DEPTH);
      exp_fv = !reset && !bus.redirect_valid && (mbuf.size() != 0);
      chk("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, exp_rv});
      if (exp_rv) chk("req_addr", bus.imem_req_addr, m_req_pc);
      chk("fetch_valid", {31'b0, bus.fetch_valid}, {31'b0, exp_fv});
      if (exp_fv) begin
         chk("fetch_pc", bus.fetch_pc, mbuf[0].pc);
         chk("fetch_instr", bus.fetch_instr, mbuf[0].instr);
      end
      if (!reset && bus.imem_rsp_valid)
         chk("rsp_credit", {31'b0, (m_inflight != 0) || allow_stray}, 32'd1);
   endtask

   task automatic model_update();
      bit rv, fire, rok;
      if (reset) begin
         mbuf.delete();
         m_inflight = 0;
         m_drop     = 0;
         m_req_pc   = RESET_PC;
         m_rsp_pc   = RESET_PC;
      end else begin
         rv   = !bus.redirect_valid && (mbuf.size() + m_inflight < DEPTH);
         fire = rv && bus.imem_req_ready;
         rok  = bus.imem_rsp_valid && (m_inflight > 0);
         if (bus.redirect_valid) begin
            mbuf.delete();
            if (rok) m_inflight--;
            m_drop   = m_inflight;
            m_req_pc = bus.redirect_pc & ~32'h3;
            m_rsp_pc = bus.redirect_pc & ~32'h3;
         end else begin
            if (mbuf.size() > 0 && bus.fetch_ready) void'(mbuf.pop_front());
            if (rok) begin
               m_inflight--;
               if (m_drop > 0) m_drop--;
               else begin
                  mbuf.push_back('{pc: m_rsp_pc, instr: bus.imem_rsp_data});
                  m_rsp_pc += 32'd4;
               end
            end
            if (fire) begin
               m_req_pc += 32'd4;
               m_inflight++;
            end
         end
      end
   endtask

   task automatic step();
      int due;
      @(negedge clk);
      cyc++;
      reset = f_reset;
      if (f_reset && !keep_mem) memq.delete();
      case (rdy_mode)
         0:       bus.imem_req_ready = 1'b1;
         1:       bus.imem_req_ready = cyc[0];
         2:       bus.imem_req_ready = 1'($urandom_range(0, 1));
         default: bus.imem_req_ready = 1'b0;
      endcase
      case (fr_mode)
         0:       bus.fetch_ready = 1'b0;
         1:       bus.fetch_ready = 1'b1;
         default: bus.fetch_ready = 1'($urandom_range(0, 1));
      endcase
      if (f_redir) begin
         bus.redirect_valid = 1'b1;
         bus.redirect_pc    = f_redir_pc;
         f_redir            = 1'b0;
      end else if (redir_rate > 0 && $urandom_range(0, 999) < redir_rate) begin
         bus.redirect_valid = 1'b1;
         bus.redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
      end else begin
         bus.redirect_valid = 1'b0;
         bus.redirect_pc    = $urandom;
      end
      if (memq.size() > 0 && memq[0].due <= cyc) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = mdat(memq[0].addr);
         void'(memq.pop_front());
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = $urandom;
      end
      #1;
      compare();
      obs_rv  = bus.imem_req_valid;
      obs_fv  = bus.fetch_valid;
      obs_pc  = bus.fetch_pc;
      obs_rsp = bus.imem_rsp_valid;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
         due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
         last_due = due;
         memq.push_back('{addr: bus.imem_req_addr, due: due});
         fire_addrs.push_back(bus.imem_req_addr);
         fires++;
         if (first_fire < 0) first_fire = cyc;
      end
      if (bus.fetch_valid && first_fv < 0) first_fv = cyc;
      if (bus.fetch_valid && bus.fetch_ready) begin
         popped.push_back(bus.fetch_pc);
         popped_instr.push_back(bus.fetch_instr);
      end
      @(posedge clk);
      model_update();
   endtask

   task automatic clear_obs();
      popped.delete();
      popped_instr.delete();
      fire_addrs.delete();
      fires      = 0;
      first_fire = -1;
      first_fv   = -1;
   endtask

   task automatic do_reset();
      f_reset = 1'b1;
      repeat (2) step();
      f_reset = 1'b0;
      clear_obs();
   endtask

   task automatic run_until_fires(input int n);
      int budget;
      budget = 0;
      while (fires < n && budget < 30) begin
         step();
         budget++;
      end
      chk("fire_budget", {31'b0, fires >= n}, 32'd1);
   endtask

   initial begin
      reset              = 1'b1;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.fetch_ready    = 1'b0;
      mbuf.delete();
      m_inflight = 0;
      m_drop     = 0;
      m_req_pc   = RESET_PC;
      m_rsp_pc   = RESET_PC;

      // reset state, then streaming with single-cycle memory
      repeat (3) step();
      chk("rst_req_valid", {31'b0, obs_rv}, 32'd0);
      chk("rst_fetch_valid", {31'b0, obs_fv}, 32'd0);
      f_reset = 1'b0;
      clear_obs();
      repeat (12) step();
      chk("p1_latency", first_fv - first_fire, 32'd2);
      chk("p1_pops", popped.size(), 32'd10);
      for (int i = 0; i < 4; i++) chk("p1_pc", popped[i], 32'(4 * i));

      // core stall fills exactly DEPTH credits
      do_reset();
      fr_mode = 0;
      repeat (10) step();
      chk("p2_fires", fires, 32'd4);
      chk("p2_req_blocked", {31'b0, obs_rv}, 32'd0);
      chk("p2_head_valid", {31'b0, obs_fv}, 32'd1);
      chk("p2_head_pc", obs_pc, 32'h0);
      fr_mode = 1;
      repeat (6) step();
      chk("p2_drain_cnt", {31'b0, popped.size() >= 4}, 32'd1);
      for (int i = 0; i < 4; i++) chk("p2_drain_pc", popped[i], 32'(4 * i));

      // redirect with two responses in flight on slow memory
      do_reset();
      lat = 3;
      run_until_fires(2);
      popped.delete();
      popped_instr.delete();
      f_redir    = 1'b1;
      f_redir_pc = 32'h0000_0101;
      step();
      chk("p3_redir_fv", {31'b0, obs_fv}, 32'd0);
      repeat (10) step();
      chk("p3_pops", {31'b0, popped.size() >= 2}, 32'd1);
      chk("p3_first_pc", popped[0], 32'h100);
      chk("p3_first_instr", popped_instr[0], mdat(32'h100));
      chk("p3_second_pc", popped[1], 32'h104);

      // redirect coinciding with a response and fetch_ready
      do_reset();
      lat = 1;
      repeat (6) step();
      clear_obs();
      f_redir    = 1'b1;
      f_redir_pc = 32'h0000_0100;
      step();
      chk("p4_rsp_same_cycle", {31'b0, obs_rsp}, 32'd1);
      chk("p4_no_pop", popped.size(), 32'd0);
      repeat (5) step();
      chk("p4_next_addr", fire_addrs[0], 32'h100);
      chk("p4_first_pc", popped[0], 32'h100);

      // toggling memory ready, random core stalls, redirect near the top of memory
      do_reset();
      rdy_mode = 1;
      fr_mode  = 2;
      lat      = 2;
      repeat (20) step();
      f_redir    = 1'b1;
      f_redir_pc = 32'hFFFF_FFFE;
      step();
      popped.delete();
      repeat (60) step();
      chk("p5_pops", {31'b0, popped.size() >= 2}, 32'd1);
      chk("p5_top_pc", popped[0], 32'hFFFF_FFFC);
      chk("p5_wrap_pc", popped[1], 32'h0);

      // long random soak with redirects
      rdy_mode   = 2;
      redir_rate = 20;
      for (int i = 0; i < 3000; i++) begin
         lat = $urandom_range(1, 4);
         step();
      end

      // reset with two requests outstanding; their late responses must be ignored
      redir_rate = 0;
      rdy_mode   = 0;
      fr_mode    = 1;
      lat        = 4;
      do_reset();
      run_until_fires(2);
      rdy_mode = 3;
      keep_mem = 1'b1;
      f_reset  = 1'b1;
      step();
      f_reset     = 1'b0;
      keep_mem    = 1'b0;
      allow_stray = 1'b1;
      clear_obs();
      repeat (8) step();
      chk("p6_stale_delivered", memq.size(), 32'd0);
      chk("p6_no_valid", first_fv, 32'hFFFF_FFFF);
      allow_stray = 1'b0;
      rdy_mode    = 0;
      repeat (10) step();
      chk("p6_restart_addr", fire_addrs[0], RESET_PC);
      chk("p6_restart_pc", popped[0], RESET_PC);
      chk("p6_restart_instr", popped_instr[0], mdat(RESET_PC));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
